lsb_extractor_seq: RTL
======================

// Module: lsb_extractor_seq
// PURPOSE
//  Receive side of the LSB audio-steganography path: the inverse of the LSB bit changer.
//  - Takes one audio sample per accepted transfer and recovers its hidden message bit from sample bit 0.
//  - Assembles MSG_WIDTH consecutive bits into one message word.
//  - Hands the word downstream over a valid/ack handshake; back-pressures upstream when the output slot is full.
// PARAMETERS
//  BPS        24  bits per sample (width of in_frame)
//  MSG_WIDTH   8  bits per recovered message word, >=2
//  MSB_FIRST   1  1: first received bit -> out_message[MSG_WIDTH-1]; 0: first bit -> out_message[0]
// PORTS
//  in_clk        in   1          clock, all logic on posedge
//  in_rst        in   1          reset, asynchronous, active-high
//  in_enable     in   1          sample valid from upstream
//  in_frame      in   BPS        audio sample carrying one message bit in bit 0
//  in_clear      in   1          sync restart of word assembly (e.g. new message start)
//  in_ack        in   1          downstream has consumed out_message
//  out_accept    out  1          block can take a sample this cycle (registered)
//  out_message   out  MSG_WIDTH  recovered message word
//  out_ready     out  1          out_message valid (registered)
//  out_word_cnt  out  16         count of words delivered to out_message, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (in_rst=1, async): state=s_COLLECT, bit counter=0, shift reg=0, out_message=0,
//   out_ready=0, out_word_cnt=0, out_accept=0; out_accept rises on first edge after release.
//  Sample accepted on posedge iff in_enable & out_accept & ~in_clear; samples at other times dropped.
//  Only in_frame[0] is used; bits [BPS-1:1] ignored.
//  Bit counter 0..MSG_WIDTH-1 counts accepted bits of the current word.
//  States:
//   s_COLLECT: out_accept=1. On accept, shift bit in; counter++.
//    On the accept of bit MSG_WIDTH (counter==MSG_WIDTH-1): counter->0.
//    If slot free (out_ready=0 or in_ack=1 this cycle): load word into out_message, out_ready=1,
//    out_word_cnt++, all at that same edge (latency 1 clk from last bit); stay s_COLLECT.
//    Else: keep word in shift reg, go s_HOLD, out_accept->0 at that edge.
//   s_HOLD: out_accept=0. On in_ack: load held word to out_message, out_ready stays 1,
//    out_word_cnt++, go s_COLLECT, out_accept->1 at that edge.
//  out_ready: set on word load; cleared on in_ack when no new word loads in the same edge.
//  in_ack with out_ready=0 ignored.
//  in_clear (priority over in_enable): counter=0, shift reg=0, state->s_COLLECT, out_accept->1;
//   a word held in s_HOLD is discarded; out_message/out_ready/out_word_cnt untouched.
//  Bit order: MSB_FIRST=1 shift left, new bit into bit 0; MSB_FIRST=0 shift right, new bit into MSB.
//  in_rst mid-word: partial word lost, all outputs to reset values immediately.
// TESTING
//  T1 MSB_FIRST=1: 8 samples, LSBs 1,0,1,0,0,1,1,0, in_ack held 1 -> out_message=0xA6, out_ready 1 clk after 8th accept, out_word_cnt=1.
//  T2 MSB_FIRST=0, same LSBs -> out_message=0x65; upper sample bits random (e.g. 0xABCDE?) do not affect result.
//  T3 Back-pressure: in_ack=0, send 16 bits (0xA6 then 0x3C) -> after word 2 out_accept=0, out_message=0xA6; pulse in_ack -> out_message=0x3C, out_ready=1, out_accept=1, cnt=2.
//  T4 Simultaneous: in_ack=1 on the edge accepting bit 8 of word 2 -> no s_HOLD, out_message=word 2, out_ready stays 1.
//  T5 in_clear after 5 bits, then 8 bits for 0x5A -> out_message=0x5A; in_clear with in_enable same clk -> sample dropped.
//  T6 Reset mid-word after 3 bits, then 0xFF word; separately force 65536 words -> out_word_cnt wraps to 0, no glitch on out_ready.

Source files
------------

// File: rtl/lsb_extractor_seq.sv
// lsb_extractor_seq: recovers hidden message bits from audio sample LSBs and
// assembles them into words handed downstream over a valid/ack handshake.
module lsb_extractor_seq #(
  parameter int unsigned BPS       = 24,
  parameter int unsigned MSG_WIDTH = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_enable,
  input  logic [BPS-1:0]       in_frame,
  input  logic                 in_clear,
  input  logic                 in_ack,
  output logic                 out_accept,
  output logic [MSG_WIDTH-1:0] out_message,
  output logic                 out_ready,
  output logic [15:0]          out_word_cnt
);

  localparam int unsigned CNT_W = (MSG_WIDTH > 2) ? $clog2(MSG_WIDTH) : 1;
  localparam int unsigned WCNT_W = 16;

  typedef enum logic {
    s_COLLECT = 1'b0,
    s_HOLD    = 1'b1
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [MSG_WIDTH-1:0] r_shift;
  logic [MSG_WIDTH-1:0] r_msg;
  logic                 r_ready;
  logic                 r_accept;
  logic [WCNT_W-1:0]    r_wcnt;

  state_t               w_state_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [MSG_WIDTH-1:0] w_shift_nxt;
  logic [MSG_WIDTH-1:0] w_msg_nxt;
  logic                 w_ready_nxt;
  logic                 w_accept_nxt;
  logic [WCNT_W-1:0]    w_wcnt_nxt;
  logic                 w_load;
  logic                 w_take;
  logic                 w_slot_free;
  logic                 w_last_bit;
  logic [MSG_WIDTH-1:0] w_shifted;
  logic                 w_unused_frame;

  // Only the sample LSB carries payload; the audio bits above it are ignored.
  assign w_unused_frame = ^in_frame[BPS-1:1];

  assign w_take      = in_enable & r_accept & ~in_clear;
  assign w_slot_free = ~r_ready | in_ack;
  assign w_last_bit  = (r_cnt == CNT_W'(MSG_WIDTH - 1));

  // Shift the new bit in from the end matching the configured bit order.
  always_comb begin
    w_shifted = r_shift;
    if (MSB_FIRST) begin
      w_shifted = {r_shift[MSG_WIDTH-2:0], in_frame[0]};
    end else begin
      w_shifted = {in_frame[0], r_shift[MSG_WIDTH-1:1]};
    end
  end

  // Next-state, word assembly and output-slot handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_msg_nxt   = r_msg;
    w_ready_nxt = r_ready;
    w_wcnt_nxt  = r_wcnt;
    w_load      = 1'b0;

    if (in_clear) begin
      w_state_nxt = s_COLLECT;
      w_cnt_nxt   = '0;
      w_shift_nxt = '0;
    end else begin
      case (r_state)
        s_COLLECT: begin
          if (w_take) begin
            if (w_last_bit) begin
              w_cnt_nxt = '0;
              if (w_slot_free) begin
                w_msg_nxt   = w_shifted;
                w_shift_nxt = '0;
                w_load      = 1'b1;
              end else begin
                w_shift_nxt = w_shifted;
                w_state_nxt = s_HOLD;
              end
            end else begin
              w_cnt_nxt   = r_cnt + CNT_W'(1);
              w_shift_nxt = w_shifted;
            end
          end
        end
        s_HOLD: begin
          if (in_ack && r_ready) begin
            w_msg_nxt   = r_shift;
            w_shift_nxt = '0;
            w_load      = 1'b1;
            w_state_nxt = s_COLLECT;
          end
        end
        default: w_state_nxt = s_COLLECT;
      endcase
    end

    if (w_load) begin
      w_ready_nxt = 1'b1;
      w_wcnt_nxt  = r_wcnt + WCNT_W'(1);
    end else if (in_ack) begin
      w_ready_nxt = 1'b0;
    end

    w_accept_nxt = (w_state_nxt == s_COLLECT);
  end

  // State and registered outputs; accept stays low until the first edge after reset.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_state  <= s_COLLECT;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_msg    <= '0;
      r_ready  <= 1'b0;
      r_accept <= 1'b0;
      r_wcnt   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shift  <= w_shift_nxt;
      r_msg    <= w_msg_nxt;
      r_ready  <= w_ready_nxt;
      r_accept <= w_accept_nxt;
      r_wcnt   <= w_wcnt_nxt;
    end
  end

  assign out_accept   = r_accept;
  assign out_message  = r_msg;
  assign out_ready    = r_ready;
  assign out_word_cnt = r_wcnt;

endmodule
